mem_des: RTL and testbench

MEM_DES -- requirements
Module: mem_des

---
 rtl/mem_des_pkg.sv | 21 ++
 rtl/mem_des.sv | 109 ++++++++++
 tb/tb_mem_des.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_des_pkg.sv
// ============================================================================
// Module  : mem_des_pkg
// Brief   : Shared FSM state type and default geometry for mem_des.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_des_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE_ACK = 2'd1,
        READ_ACK  = 2'd2
    } state_e;

endpackage : mem_des_pkg

`default_nettype wire

// File: rtl/mem_des.sv
// ============================================================================
// Module  : mem_des
// Brief   : Single-port request/acknowledge memory with registered read data.
//           Define MEM_DES_CLEAR_ON_RST_EN to zero the array while in reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_des
    import mem_des_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int ADDRWIDTH = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADDRWIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 valid_i,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 ready_o
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    state_e                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]       rdata_q, rdata_d;
    logic                   ready_q, ready_d;

    logic                   w_wr_fire;
    logic                   w_wr_in_range;
    logic                   w_rd_in_range;

    // Out-of-range checks only matter when DEPTH is not a power of two.
    assign w_wr_in_range = (32'(addr_i) < 32'(DEPTH));
    assign w_rd_in_range = (32'(addr_q) < 32'(DEPTH));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        w_wr_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i && wr_en) begin
                    w_wr_fire = 1'b1;
                    state_d   = WRITE_ACK;
                end else if (valid_i && rd_en) begin
                    addr_d  = addr_i;
                    state_d = READ_ACK;
                end
            end
            WRITE_ACK: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            READ_ACK: begin
                ready_d = 1'b1;
                rdata_d = w_rd_in_range ? mem[addr_q] : '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // A write seen on a reset edge is discarded in both build variants.
    always_ff @(posedge clk_i) begin
`ifdef MEM_DES_CLEAR_ON_RST_EN
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (w_wr_fire && w_wr_in_range) begin
            mem[addr_i] <= wdata_i;
        end
`else
        if (rst_i && w_wr_fire && w_wr_in_range) begin
            mem[addr_i] <= wdata_i;
        end
`endif
    end

    assign rdata_o = rdata_q;
    assign ready_o = ready_q;

endmodule : mem_des

`default_nettype wire

// File: tb/tb_mem_des.sv
// ============================================================================
// Module  : tb_mem_des
// Brief   : Self-checking bench for mem_des against a behavioural memory model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_des;

    localparam int W = 16;
    localparam int D = 16;
    localparam int A = 4;

    logic         clk_i   = 1'b0;
    logic         rst_i   = 1'b0;
    logic [A-1:0] addr_i  = '0;
    logic [W-1:0] wdata_i = '0;
    logic         valid_i = 1'b0;
    logic         wr_en   = 1'b0;
    logic         rd_en   = 1'b0;
    logic [W-1:0] rdata_o;
    logic         ready_o;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] model_mem [D];
    logic [W-1:0] model_rdata;

    mem_des #(.WIDTH(W), .DEPTH(D), .ADDRWIDTH(A)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .valid_i (valid_i),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .rdata_o (rdata_o),
        .ready_o (ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One request presented for a single cycle; watches a fixed window afterwards.
    task automatic do_req(input logic w, input logic r, input logic [A-1:0] a,
                          input logic [W-1:0] d, output int cnt, output int lat,
                          output logic [W-1:0] rd);
        cnt = 0; lat = -1; rd = '0;
        valid_i = 1'b1; wr_en = w; rd_en = r; addr_i = a; wdata_i = d;
        tick();
        valid_i = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        if (ready_o) cnt++;
        for (int k = 2; k <= 6; k++) begin
            tick();
            if (ready_o) begin
                if (cnt == 0) begin
                    lat = k;
                    rd  = rdata_o;
                end
                cnt++;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        valid_i = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        tick(); tick();
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        checks++;
        if (rdata_o !== '0) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", rdata_o); end
        rst_i = 1'b1;
        tick();
        model_rdata = '0;
    endtask

    task automatic test_frontdoor();
        int cnt, lat;
        logic [W-1:0] rd, d;
        for (int i = 0; i < D; i++) begin
            d = 16'hA000 ^ W'(i * 16'h0137);
            do_req(1'b1, 1'b0, A'(i), d, cnt, lat, rd);
            model_mem[i] = d;
            checks++;
            if (cnt !== 1 || lat !== 2) begin errors++; $display("FAIL fd_write_ack addr=%0d cnt=%0d lat=%0d exp cnt=1 lat=2", i, cnt, lat); end
        end
        for (int i = 0; i < D; i++) begin
            do_req(1'b0, 1'b1, A'(i), '0, cnt, lat, rd);
            model_rdata = model_mem[i];
            checks++;
            if (cnt !== 1 || lat !== 2) begin errors++; $display("FAIL fd_read_ack addr=%0d cnt=%0d lat=%0d exp cnt=1 lat=2", i, cnt, lat); end
            checks++;
            if (rd !== model_mem[i]) begin errors++; $display("FAIL fd_read_data addr=%0d got=%h exp=%h", i, rd, model_mem[i]); end
        end
    endtask

    task automatic test_backdoor_load();
        int cnt, lat;
        logic [W-1:0] rd;
        for (int i = 0; i < D; i++) begin
            dut.mem[i] = W'(i);
            model_mem[i] = W'(i);
        end
        for (int i = 0; i < D; i++) begin
            do_req(1'b0, 1'b1, A'(i), '0, cnt, lat, rd);
            model_rdata = model_mem[i];
            checks++;
            if (cnt !== 1 || rd !== W'(i)) begin errors++; $display("FAIL bd_load_read addr=%0d got=%h cnt=%0d exp=%h cnt=1", i, rd, cnt, W'(i)); end
        end
    endtask

    task automatic test_backdoor_dump();
        int cnt, lat;
        logic [W-1:0] rd;
        do_req(1'b1, 1'b0, A'(5), 16'hA5A5, cnt, lat, rd);
        model_mem[5] = 16'hA5A5;
        checks++;
        if (dut.mem[5] !== 16'hA5A5) begin errors++; $display("FAIL bd_dump got=%h exp=a5a5", dut.mem[5]); end
        for (int i = 0; i < D; i++) begin
            checks++;
            if (dut.mem[i] !== model_mem[i]) begin errors++; $display("FAIL bd_dump_all addr=%0d got=%h exp=%h", i, dut.mem[i], model_mem[i]); end
        end
    endtask

    task automatic test_write_priority();
        int cnt, lat;
        logic [W-1:0] rd;
        do_req(1'b0, 1'b1, A'(7), '0, cnt, lat, rd);
        model_rdata = model_mem[7];
        do_req(1'b1, 1'b1, A'(3), 16'h1234, cnt, lat, rd);
        model_mem[3] = 16'h1234;
        checks++;
        if (dut.mem[3] !== 16'h1234) begin errors++; $display("FAIL prio_mem got=%h exp=1234", dut.mem[3]); end
        checks++;
        if (rdata_o !== model_rdata || rd !== model_rdata) begin errors++; $display("FAIL prio_rdata_hold got=%h exp=%h", rdata_o, model_rdata); end
        checks++;
        if (cnt !== 1) begin errors++; $display("FAIL prio_ready_cnt got=%0d exp=1", cnt); end
    endtask

    task automatic test_idle_no_action();
        int seen = 0;
        valid_i = 1'b0; wr_en = 1'b1; rd_en = 1'b0; addr_i = A'(9); wdata_i = ~model_mem[9];
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ready_o) seen++;
        end
        valid_i = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ready_o) seen++;
        end
        valid_i = 1'b0;
        tick();
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL idle_ready got=%0d pulses exp=0", seen); end
        checks++;
        if (dut.mem[9] !== model_mem[9]) begin errors++; $display("FAIL idle_mem got=%h exp=%h", dut.mem[9], model_mem[9]); end
        checks++;
        if (rdata_o !== model_rdata) begin errors++; $display("FAIL idle_rdata got=%h exp=%h", rdata_o, model_rdata); end
    endtask

    task automatic test_random();
        int cnt, lat;
        logic [W-1:0] rd, d;
        logic [A-1:0] a;
        for (int n = 0; n < 60; n++) begin
            a = A'($urandom_range(0, D - 1));
            d = W'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_req(1'b1, 1'($urandom_range(0, 1)), a, d, cnt, lat, rd);
                model_mem[a] = d;
                checks++;
                if (cnt !== 1 || lat !== 2 || rdata_o !== model_rdata) begin
                    errors++; $display("FAIL rnd_write n=%0d cnt=%0d lat=%0d rdata=%h exp cnt=1 lat=2 rdata=%h", n, cnt, lat, rdata_o, model_rdata);
                end
            end else begin
                do_req(1'b0, 1'b1, a, d, cnt, lat, rd);
                model_rdata = model_mem[a];
                checks++;
                if (cnt !== 1 || lat !== 2 || rd !== model_mem[a]) begin
                    errors++; $display("FAIL rnd_read n=%0d addr=%0d got=%h cnt=%0d lat=%0d exp=%h cnt=1 lat=2", n, a, rd, cnt, lat, model_mem[a]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int cnt, lat;
        logic [W-1:0] rd;
        valid_i = 1'b1; wr_en = 1'b1; rd_en = 1'b0; addr_i = A'(11); wdata_i = 16'hBEEF;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ready_o) pulses++;
        end
        valid_i = 1'b0; wr_en = 1'b0;
        tick(); tick();
        model_mem[11] = 16'hBEEF;
        checks++;
        if (pulses !== 5) begin errors++; $display("FAIL b2b_pulses got=%0d exp=5", pulses); end
        do_req(1'b0, 1'b1, A'(11), '0, cnt, lat, rd);
        model_rdata = model_mem[11];
        checks++;
        if (rd !== 16'hBEEF) begin errors++; $display("FAIL b2b_readback got=%h exp=beef", rd); end
    endtask

    task automatic test_reset_abort();
        int cnt, lat;
        int seen = 0;
        logic [W-1:0] rd;
        do_req(1'b1, 1'b0, A'(2), 16'hC3C3, cnt, lat, rd);
        model_mem[2] = 16'hC3C3;
        do_req(1'b0, 1'b1, A'(2), '0, cnt, lat, rd);
        model_rdata = 16'hC3C3;
        valid_i = 1'b1; rd_en = 1'b1; addr_i = A'(6);
        tick();
        valid_i = 1'b0; rd_en = 1'b0;
        rst_i = 1'b0;
        valid_i = 1'b1; wr_en = 1'b1; addr_i = A'(4); wdata_i = 16'hDEAD;
        tick();
        valid_i = 1'b0; wr_en = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || rdata_o !== '0) begin errors++; $display("FAIL abort_outputs ready=%b rdata=%h exp ready=0 rdata=0000", ready_o, rdata_o); end
        rst_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ready_o) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_no_ack got=%0d pulses exp=0", seen); end
`ifdef MEM_DES_CLEAR_ON_RST_EN
        for (int i = 0; i < D; i++) model_mem[i] = '0;
`endif
        model_rdata = '0;
        checks++;
        if (dut.mem[2] !== model_mem[2]) begin errors++; $display("FAIL abort_mem_keep got=%h exp=%h", dut.mem[2], model_mem[2]); end
        checks++;
        if (dut.mem[4] !== model_mem[4]) begin errors++; $display("FAIL abort_write_blocked got=%h exp=%h", dut.mem[4], model_mem[4]); end
        do_req(1'b0, 1'b1, A'(2), '0, cnt, lat, rd);
        checks++;
        if (cnt !== 1 || rd !== model_mem[2]) begin errors++; $display("FAIL abort_recover got=%h cnt=%0d exp=%h cnt=1", rd, cnt, model_mem[2]); end
    endtask

    initial begin
        for (int i = 0; i < D; i++) model_mem[i] = '0;
        model_rdata = '0;
        #2;
        test_reset();
        test_frontdoor();
        test_backdoor_load();
        test_backdoor_dump();
        test_write_priority();
        test_idle_no_action();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_des

`default_nettype wire
